debounce_scan_ctrl: RTL and testbench



---
 rtl/debounce_pkg.sv | 22 ++
 rtl/debounce_tick_gen.sv | 25 ++
 rtl/debounce_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_debounce_scan_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the scanned switch debouncer.
// The optional auto-repeat feature is enabled by defining DEBOUNCE_SCAN_REPEAT_EN.
package debounce_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  localparam int DefNumSw        = 4;
  localparam int DefClksPerTick  = 2500;
  localparam int DefTicksLimit   = 100;
  localparam int DefRepeatTicks  = 2500;

  // Width that holds every count up to the larger limit minus one; never zero.
  function automatic int cnt_width(input int limitA, input int limitB);
    int maxLimit;
    maxLimit = (limitA > limitB) ? limitA : limitB;
    return (maxLimit < 2) ? 1 : $clog2(maxLimit);
  endfunction

endpackage

// File: rtl/debounce_tick_gen.sv
// Shared sample-tick prescaler: counts 0..CLKS_PER_TICK-1 and pulses o_Tick at terminal count.
module debounce_tick_gen
  import debounce_pkg::*;
#(
  parameter int CLKS_PER_TICK = DefClksPerTick
) (
  input  logic i_Clk,
  input  logic i_Reset,
  output logic o_Tick
);

  localparam int PW = (CLKS_PER_TICK < 2) ? 1 : $clog2(CLKS_PER_TICK);
  localparam logic [PW-1:0] LastCount = PW'(CLKS_PER_TICK - 1);

  logic [PW-1:0] presc_q, presc_d;

  assign o_Tick  = (presc_q == LastCount);
  assign presc_d = o_Tick ? '0 : presc_q + 1'b1;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) presc_q <= '0;
    else         presc_q <= presc_d;
  end

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Time-multiplexed debouncer: one scan FSM walks every channel once per tick through a shared datapath.
// Define DEBOUNCE_SCAN_REPEAT_EN to add auto-repeat press pulses while a switch is held.
module debounce_scan_ctrl
  import debounce_pkg::*;
#(
  parameter int NUM_SW        = DefNumSw,
  parameter int CLKS_PER_TICK = DefClksPerTick,
  parameter int TICKS_LIMIT   = DefTicksLimit,
  parameter int REPEAT_TICKS  = DefRepeatTicks
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [NUM_SW-1:0] i_Switch,
  output logic [NUM_SW-1:0] o_Switch,
  output logic [NUM_SW-1:0] o_Press,
  output logic [NUM_SW-1:0] o_Release,
  output logic              o_Scan_Busy
);

  localparam int CW = cnt_width(TICKS_LIMIT, REPEAT_TICKS);
  localparam int IW = (NUM_SW < 2) ? 1 : $clog2(NUM_SW);
  localparam logic [IW-1:0] LastIdx = IW'(NUM_SW - 1);
  localparam logic [CW-1:0] FlipCnt = CW'(TICKS_LIMIT - 1);

  logic [NUM_SW-1:0] sync1_q, sync2_q;
  logic [NUM_SW-1:0] sw_q, press_q, release_q;
  logic [CW-1:0]     cnt_q [NUM_SW];
  scan_state_e       state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              pending_q, pending_d;
  logic              tick, visit, curSync, flip, repFire;
  logic [CW-1:0]     cnt_d;

  debounce_tick_gen #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .o_Tick  (tick)
  );

  // A tick landing mid-scan is remembered so the next scan starts right after this one.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    visit     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        visit = 1'b1;
        if (idx_q == LastIdx) begin
          idx_d = '0;
          if (pending_q || tick) begin
            state_d   = SCAN;
            pending_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          idx_d = idx_q + 1'b1;
          if (tick) pending_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      sync1_q   <= '0;
      sync2_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      sync1_q   <= i_Switch;
      sync2_q   <= sync1_q;
    end
  end

  assign curSync = sync2_q[idx_q];

  // Shared compare/update for the channel being visited this cycle.
  always_comb begin
    cnt_d = cnt_q[idx_q];
    flip  = 1'b0;
    if (curSync != sw_q[idx_q]) begin
      if (cnt_q[idx_q] == FlipCnt) begin
        flip  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q[idx_q] + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

`ifdef DEBOUNCE_SCAN_REPEAT_EN
  localparam logic [CW-1:0] RepeatCnt = CW'(REPEAT_TICKS - 1);

  logic [CW-1:0] rep_q [NUM_SW];
  logic [CW-1:0] rep_d;

  // Separate hold counter so a repeat count in progress never shortens a release debounce.
  always_comb begin
    rep_d   = '0;
    repFire = 1'b0;
    if (curSync && sw_q[idx_q]) begin
      if (rep_q[idx_q] == RepeatCnt) repFire = 1'b1;
      else                           rep_d   = rep_q[idx_q] + 1'b1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset)    rep_q        <= '{default: '0};
    else if (visit) rep_q[idx_q] <= rep_d;
  end
`else
  assign repFire = 1'b0;
`endif

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      cnt_q     <= '{default: '0};
      sw_q      <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= '0;
      release_q <= '0;
      if (visit) begin
        cnt_q[idx_q]     <= cnt_d;
        press_q[idx_q]   <= (flip & curSync) | repFire;
        release_q[idx_q] <= flip & ~curSync;
        if (flip) sw_q[idx_q] <= curSync;
      end
    end
  end

  assign o_Switch    = sw_q;
  assign o_Press     = press_q;
  assign o_Release   = release_q;
  assign o_Scan_Busy = (state_q == SCAN);

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Scoreboard bench for debounce_scan_ctrl: a sample-level reference model predicts pulses,
// a separate monitor compares them against the DUT.
module tb_debounce_scan_ctrl;

  localparam int NUM_SW        = 4;
  localparam int CLKS_PER_TICK = 8;
  localparam int TICKS_LIMIT   = 4;
  localparam int REPEAT_TICKS  = 6;

  logic              i_Clk    = 1'b0;
  logic              i_Reset  = 1'b1;
  logic [NUM_SW-1:0] i_Switch = '0;
  logic [NUM_SW-1:0] o_Switch, o_Press, o_Release;
  logic              o_Scan_Busy;

  typedef struct {
    int edgeNum;
    int ch;
    bit isPress;
  } event_t;

  event_t            expQ[$];
  int                checks   = 0;
  int                failures = 0;
  int                edgeCnt  = 0;
  bit [NUM_SW-1:0]   h0, h1, h2;
  bit [NUM_SW-1:0]   lvl;
  int                run [NUM_SW];
  int                rep [NUM_SW];

  debounce_scan_ctrl #(
    .NUM_SW        (NUM_SW),
    .CLKS_PER_TICK (CLKS_PER_TICK),
    .TICKS_LIMIT   (TICKS_LIMIT),
    .REPEAT_TICKS  (REPEAT_TICKS)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Switch    (i_Switch),
    .o_Switch    (o_Switch),
    .o_Press     (o_Press),
    .o_Release   (o_Release),
    .o_Scan_Busy (o_Scan_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, edgeCnt, $time);
    end
  endtask

  // One debounce sample of channel c: the level flips after TICKS_LIMIT consecutive
  // disagreeing samples; a held press repeats after REPEAT_TICKS agreeing samples.
  task automatic modelSample(input int c, input bit s);
    if (s != lvl[c]) begin
      run[c]++;
      rep[c] = 0;
      if (run[c] == TICKS_LIMIT) begin
        lvl[c] = s;
        run[c] = 0;
        expQ.push_back('{edgeNum: edgeCnt, ch: c, isPress: s});
      end
    end else begin
      run[c] = 0;
      if (lvl[c]) rep[c]++;
      else        rep[c] = 0;
`ifdef DEBOUNCE_SCAN_REPEAT_EN
      if (rep[c] == REPEAT_TICKS) begin
        rep[c] = 0;
        expQ.push_back('{edgeNum: edgeCnt, ch: c, isPress: 1'b1});
      end
`endif
    end
  endtask

  // Reference timing: tick every CLKS_PER_TICK edges after reset, channel c sampled c+1 edges later,
  // using the input as it was two edges earlier.
  always begin
    @(posedge i_Clk);
    #1;
    if (i_Reset) begin
      edgeCnt = 0;
      h0 = '0; h1 = '0; h2 = '0;
      lvl = '0;
      for (int c = 0; c < NUM_SW; c++) begin
        run[c] = 0;
        rep[c] = 0;
      end
      expQ.delete();
    end else begin
      edgeCnt++;
      h2 = h1; h1 = h0; h0 = i_Switch;
      if (edgeCnt > CLKS_PER_TICK) begin
        int c;
        c = (edgeCnt - 1) % CLKS_PER_TICK;
        if (c < NUM_SW) modelSample(c, h2[c]);
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT pulses, and tracks level/busy every cycle.
  always begin
    @(negedge i_Clk);
    if (i_Reset) begin
      checkOutput("reset_outputs", int'({o_Switch, o_Press, o_Release, o_Scan_Busy}), 0);
    end else begin
      checkOutput("level", int'(o_Switch), int'(lvl));
      checkOutput("busy", int'(o_Scan_Busy),
                  int'(edgeCnt >= CLKS_PER_TICK && (edgeCnt % CLKS_PER_TICK) < NUM_SW));
      for (int c = 0; c < NUM_SW; c++) begin
        if (o_Press[c] || o_Release[c]) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_pulse_ch", c, -1);
          end else begin
            event_t e;
            e = expQ.pop_front();
            checkOutput("pulse_edge", edgeCnt, e.edgeNum);
            checkOutput("pulse_ch", c, e.ch);
            checkOutput("pulse_is_press", int'(o_Press[c]), int'(e.isPress));
            checkOutput("pulse_is_release", int'(o_Release[c]), int'(!e.isPress));
          end
        end
      end
      while (expQ.size() > 0 && expQ[0].edgeNum < edgeCnt) begin
        event_t e;
        e = expQ.pop_front();
        checkOutput("missed_pulse_edge", edgeCnt, e.edgeNum);
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge i_Clk);
    #3;
  endtask

  task automatic applyStimulus(input logic [NUM_SW-1:0] sw, input int holdTicks);
    i_Switch = sw;
    waitCycles(holdTicks * CLKS_PER_TICK);
  endtask

  task automatic applyReset();
    i_Reset = 1'b1;
    waitCycles(3);
    i_Reset = 1'b0;
  endtask

  initial begin
    bit reached;
    waitCycles(3);
    i_Reset = 1'b0;

    // Reset mid-scan while channel 2 has three disagreeing samples counted.
    i_Switch = 4'b0100;
    reached  = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      waitCycles(1);
      if (run[2] == 3 && o_Scan_Busy) reached = 1'b1;
    end
    checkOutput("wait_ch2_cnt3", int'(reached), 1);
    i_Reset = 1'b1;
    #1;
    checkOutput("reset_immediate", int'({o_Switch, o_Press, o_Release, o_Scan_Busy}), 0);
    waitCycles(2);
    i_Reset = 1'b0;
    applyStimulus(4'b0100, 7);

    // Clean press on channel 0.
    applyStimulus(4'b0101, 7);

    // Bouncing channel 1, then a firm hold.
    for (int i = 0; i < 10; i++) applyStimulus(i_Switch ^ 4'b0010, 2);
    applyStimulus(4'b0111, 7);

    // Press then release channel 3.
    applyStimulus(4'b1111, 7);
    applyStimulus(4'b0111, 7);

    // All channels rise together from a clean reset.
    i_Switch = '0;
    applyReset();
    applyStimulus(4'b1111, 7);
    checkOutput("all_pressed", int'(o_Switch), 15);

    // Long hold on channel 0 (repeat pulses only exist in the repeat build).
    i_Switch = '0;
    applyReset();
    applyStimulus(4'b0001, 30);
    applyStimulus(4'b0000, 7);

    // Random bouncy activity.
    for (int i = 0; i < 300; i++) begin
      i_Switch = i_Switch ^ NUM_SW'($urandom_range(0, 15) & $urandom_range(0, 15));
      waitCycles($urandom_range(1, 48));
    end
    applyStimulus(i_Switch, 10);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
